execute_stage_muldiv: RTL and testbench
=======================================

// Module: execute_stage_muldiv
// PURPOSE
//  Registered MIPS execute stage, parametrised in datapath width, with HI/LO registers and multi-cycle
//  MULT/MULTU/MUL/DIV/DIVU. Sits between the ID/EX and EX/MEM pipeline registers. Drives Stall to the
//  hazard unit while a multi-cycle operation is in flight.
// PARAMETERS
//  WIDTH       32  datapath width; WIDTH >= 8, power of two
//  REG_AW      5   register-file address width
//  MUL_CYCLES  4   cycles from MULT/MULTU/MUL accept to result; >= 1
// PORTS
//  Clk              in   1        clock, rising edge
//  Reset            in   1        asynchronous, active-high
//  InValid          in   1        ID/EX holds a valid instruction
//  ALUOp            in   5        operation code, table below
//  ALUSrc           in   1        0: B = ReadData2; 1: B = Imm
//  RegDst           in   1        0: dest = Rt; 1: dest = Rd
//  ReadData1        in   WIDTH    operand A
//  ReadData2        in   WIDTH    rt register value
//  Imm              in   WIDTH    sign-extended immediate
//  Shamt            in   log2(W)  shift amount
//  PCPlusFour       in   WIDTH    PC of instruction + 4
//  Rt, Rd           in   REG_AW   candidate destination registers
//  Stall            out  1        high while a multi-cycle op runs; upstream must hold its inputs
//  OutValid         out  1        one-cycle pulse: the outputs below are valid
//  RegWrite         out  1        completed op writes the register file
//  ALUResult        out  WIDTH    result
//  Zero             out  1        ALUResult == 0
//  BranchTarget     out  WIDTH    PCPlusFour + (Imm << 2), modulo 2^WIDTH
//  RegDestSelected  out  REG_AW   Rd if RegDst, else Rt
//  HI, LO           out  WIDTH    architectural HI/LO registers
// BEHAVIOUR
//  Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT, 7 SLTU, 8 SLL, 9 SRL, 10 SRA, 11 MULT,
//   12 MULTU, 13 DIV, 14 DIVU, 15 MFHI, 16 MFLO, 17 MUL. Codes 18-31 give result 0, RegWrite 0.
//  Add/sub wrap modulo 2^WIDTH; no overflow trap. Shifts act on B by Shamt. SLT is signed, SLTU unsigned.
//  Reset: all outputs 0, HI = LO = 0, FSM in IDLE. Reset mid-operation aborts the op with no HI/LO update.
//  Accept: InValid & ~Stall at a rising edge. InValid while Stall is high is ignored.
//  FSM states: IDLE, MUL, DIV. Stall = (state != IDLE), decoded from registered state only.
//  Single-cycle ops (0-10, 15, 16): outputs registered at the accept edge, so latency is 1.
//   OutValid = 1 for exactly one cycle.
//  MULT/MULTU/MUL: IDLE->MUL at accept, counter = MUL_CYCLES-1; counter decrements each edge.
//   At the edge where the counter is 0: ->IDLE, OutValid = 1, and the result is written.
//   MULT/MULTU write the full 2*WIDTH product, HI = upper half, LO = lower half, with RegWrite = 0.
//   MUL writes ALUResult = lower WIDTH bits of the signed product, RegWrite = 1, and leaves HI/LO unchanged.
//  DIV/DIVU: IDLE->DIV at accept. The divider is restoring, WIDTH iterations plus one sign fix-up, so the
//   result appears WIDTH+1 edges after accept. Result: LO = quotient, HI = remainder, RegWrite = 0.
//   Signed quotient truncates toward zero; remainder takes the sign of the dividend.
//   Divisor 0: LO = all ones, HI = dividend. Signed MIN / -1: LO = MIN, HI = 0.
//  Stall is high for MUL_CYCLES cycles (mul) or WIDTH+1 cycles (div) after the accept edge.
//   A new instruction is accepted on the edge after Stall falls.
//  MFHI/MFLO read HI/LO as registered at the accept edge, so a back-to-back read after completion sees
//   the new value.
//  While busy, ALUResult, Zero, BranchTarget and RegDestSelected hold their values and OutValid = 0.
//  Operands are latched at accept, so upstream changes during Stall have no effect.
//  Zero and BranchTarget are computed from the same accepted instruction as ALUResult.
// TESTING
//  1. ADD A=5, B=Imm=-3, ALUSrc=1, RegDst=0, Rt=9 -> next cycle: ALUResult=2, Dest=9, RegWrite=1, OutValid=1.
//  2. SUB A=B=0x1234, PCPlusFour=0x100, Imm=4 -> Zero=1, BranchTarget=0x110.
//  3. MULT A=-2, B=3 -> Stall high 4 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
//     MFLO next -> ALUResult=0xFFFFFFFA.
//  4. DIV A=-7, B=2 -> Stall high 33 cycles, LO=-3, HI=-1.
//     DIVU A=7, B=0 -> LO=0xFFFFFFFF, HI=7.
//  5. InValid held with ADD during a DIV -> not accepted until Stall falls; exactly one OutValid for it.
//  6. Reset asserted mid-DIV cycle 10 -> immediate Stall=0, HI=LO=0, OutValid=0.
//     Rerun 1-5 with WIDTH=16, MUL_CYCLES=1.

Source files
------------

// File: rtl/execute_stage_muldiv.sv
// execute_stage_muldiv
//   Registered MIPS execute stage with HI/LO registers and multi-cycle
//   multiply/divide. Single-cycle ALU ops register their result at the accept
//   edge. MULT/MULTU/MUL complete MUL_CYCLES edges after accept. DIV/DIVU
//   complete WIDTH+1 edges after accept (restoring divider plus sign fix-up).
//   Stall is high while a multi-cycle op is in flight.
// Ports
//   Clk, Reset                    clock, async active-high reset
//   InValid, ALUOp, ALUSrc,       instruction from ID/EX; accepted on InValid & ~Stall
//   RegDst, ReadData1/2, Imm,
//   Shamt, PCPlusFour, Rt, Rd
//   Stall                         multi-cycle op in flight, upstream holds
//   OutValid                      one-cycle pulse qualifying the result outputs
//   RegWrite, ALUResult, Zero,    result towards EX/MEM
//   BranchTarget, RegDestSelected
//   HI, LO                        architectural HI/LO registers
//
// state  | meaning
// S_IDLE | ready to accept, single-cycle ops complete here
// S_MUL  | multiply latency countdown
// S_DIV  | restoring divide iterations, then sign fix-up when cnt hits 0
module execute_stage_muldiv #(
  parameter int WIDTH      = 32,
  parameter int REG_AW     = 5,
  parameter int MUL_CYCLES = 4
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     InValid,
  input  logic [4:0]               ALUOp,
  input  logic                     ALUSrc,
  input  logic                     RegDst,
  input  logic [WIDTH-1:0]         ReadData1,
  input  logic [WIDTH-1:0]         ReadData2,
  input  logic [WIDTH-1:0]         Imm,
  input  logic [$clog2(WIDTH)-1:0] Shamt,
  input  logic [WIDTH-1:0]         PCPlusFour,
  input  logic [REG_AW-1:0]        Rt,
  input  logic [REG_AW-1:0]        Rd,
  output logic                     Stall,
  output logic                     OutValid,
  output logic                     RegWrite,
  output logic [WIDTH-1:0]         ALUResult,
  output logic                     Zero,
  output logic [WIDTH-1:0]         BranchTarget,
  output logic [REG_AW-1:0]        RegDestSelected,
  output logic [WIDTH-1:0]         HI,
  output logic [WIDTH-1:0]         LO
);

  localparam logic [4:0] OP_ADD = 5'd0, OP_SUB = 5'd1, OP_AND = 5'd2, OP_OR = 5'd3;
  localparam logic [4:0] OP_XOR = 5'd4, OP_NOR = 5'd5, OP_SLT = 5'd6, OP_SLTU = 5'd7;
  localparam logic [4:0] OP_SLL = 5'd8, OP_SRL = 5'd9, OP_SRA = 5'd10, OP_MULT = 5'd11;
  localparam logic [4:0] OP_MULTU = 5'd12, OP_DIV = 5'd13, OP_DIVU = 5'd14;
  localparam logic [4:0] OP_MFHI = 5'd15, OP_MFLO = 5'd16, OP_MUL = 5'd17;

  localparam int CNT_MAX = (WIDTH > MUL_CYCLES) ? WIDTH : MUL_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  state_t state, state_next;

  logic [CNT_W-1:0]  cnt;
  logic [4:0]        op_q;
  logic [WIDTH-1:0]  a_q, b_q, bt_q;
  logic [REG_AW-1:0] dest_q;
  logic [WIDTH-1:0]  rem_q, quo_q, dvsr_q;
  logic              neg_quo_q, neg_rem_q;

  logic              accept, is_mul_op, is_div_op, a_neg, b_neg;
  logic [WIDTH-1:0]  b_sel, bt_sel, alu_res;
  logic [REG_AW-1:0] dest_sel;
  logic              alu_rw;
  logic [2*WIDTH-1:0] prod_s, prod_u;
  logic [WIDTH:0]    rem_sh, diff;
  logic              fits;
  logic [WIDTH-1:0]  rem_nx, quo_nx, quo_fix, rem_fix;

  assign Stall     = (state != S_IDLE);
  assign accept    = InValid & ~Stall;
  assign is_mul_op = (ALUOp == OP_MULT) || (ALUOp == OP_MULTU) || (ALUOp == OP_MUL);
  assign is_div_op = (ALUOp == OP_DIV) || (ALUOp == OP_DIVU);

  assign b_sel    = ALUSrc ? Imm : ReadData2;
  assign dest_sel = RegDst ? Rd : Rt;
  assign bt_sel   = PCPlusFour + (Imm << 2);

  // Divider works on magnitudes; signs are restored in the fix-up cycle.
  assign a_neg = (ALUOp == OP_DIV) & ReadData1[WIDTH-1];
  assign b_neg = (ALUOp == OP_DIV) & b_sel[WIDTH-1];

  assign prod_s = {{WIDTH{a_q[WIDTH-1]}}, a_q} * {{WIDTH{b_q[WIDTH-1]}}, b_q};
  assign prod_u = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};

  // Remainder stays below the divisor, so diff[WIDTH] is a clean borrow flag.
  assign rem_sh  = {rem_q, quo_q[WIDTH-1]};
  assign diff    = rem_sh - {1'b0, dvsr_q};
  assign fits    = ~diff[WIDTH];
  assign rem_nx  = fits ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
  assign quo_nx  = {quo_q[WIDTH-2:0], fits};
  assign quo_fix = neg_quo_q ? -quo_q : quo_q;
  assign rem_fix = neg_rem_q ? -rem_q : rem_q;

  always_comb begin
    alu_res = '0;
    alu_rw  = 1'b1;
    case (ALUOp)
      OP_ADD:  alu_res = ReadData1 + b_sel;
      OP_SUB:  alu_res = ReadData1 - b_sel;
      OP_AND:  alu_res = ReadData1 & b_sel;
      OP_OR:   alu_res = ReadData1 | b_sel;
      OP_XOR:  alu_res = ReadData1 ^ b_sel;
      OP_NOR:  alu_res = ~(ReadData1 | b_sel);
      OP_SLT:  alu_res = WIDTH'($signed(ReadData1) < $signed(b_sel));
      OP_SLTU: alu_res = WIDTH'(ReadData1 < b_sel);
      OP_SLL:  alu_res = b_sel << Shamt;
      OP_SRL:  alu_res = b_sel >> Shamt;
      OP_SRA:  alu_res = $signed(b_sel) >>> Shamt;
      OP_MFHI: alu_res = HI;
      OP_MFLO: alu_res = LO;
      default: alu_rw  = 1'b0;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (accept && is_mul_op)      state_next = S_MUL;
        else if (accept && is_div_op) state_next = S_DIV;
      end
      S_MUL:   if (cnt == '0) state_next = S_IDLE;
      S_DIV:   if (cnt == '0) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt <= '0; op_q <= '0; a_q <= '0; b_q <= '0; bt_q <= '0; dest_q <= '0;
      rem_q <= '0; quo_q <= '0; dvsr_q <= '0; neg_quo_q <= 1'b0; neg_rem_q <= 1'b0;
      OutValid <= 1'b0; RegWrite <= 1'b0; ALUResult <= '0; Zero <= 1'b0;
      BranchTarget <= '0; RegDestSelected <= '0; HI <= '0; LO <= '0;
    end else begin
      OutValid <= 1'b0;
      RegWrite <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_q   <= ALUOp;
            a_q    <= ReadData1;
            b_q    <= b_sel;
            bt_q   <= bt_sel;
            dest_q <= dest_sel;
            if (is_mul_op) begin
              cnt <= CNT_W'(MUL_CYCLES - 1);
            end else if (is_div_op) begin
              cnt       <= CNT_W'(WIDTH);
              rem_q     <= '0;
              quo_q     <= a_neg ? -ReadData1 : ReadData1;
              dvsr_q    <= b_neg ? -b_sel : b_sel;
              neg_quo_q <= a_neg ^ b_neg;
              neg_rem_q <= a_neg;
            end else begin
              ALUResult       <= alu_res;
              Zero            <= (alu_res == '0);
              BranchTarget    <= bt_sel;
              RegDestSelected <= dest_sel;
              RegWrite        <= alu_rw;
              OutValid        <= 1'b1;
            end
          end
        end
        S_MUL: begin
          if (cnt == '0) begin
            OutValid        <= 1'b1;
            BranchTarget    <= bt_q;
            RegDestSelected <= dest_q;
            if (op_q == OP_MUL) begin
              ALUResult <= prod_s[WIDTH-1:0];
              Zero      <= (prod_s[WIDTH-1:0] == '0);
              RegWrite  <= 1'b1;
            end else begin
              ALUResult <= '0;
              Zero      <= 1'b1;
              {HI, LO}  <= (op_q == OP_MULT) ? prod_s : prod_u;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_DIV: begin
          if (cnt != '0) begin
            rem_q <= rem_nx;
            quo_q <= quo_nx;
            cnt   <= cnt - CNT_W'(1);
          end else begin
            OutValid        <= 1'b1;
            ALUResult       <= '0;
            Zero            <= 1'b1;
            BranchTarget    <= bt_q;
            RegDestSelected <= dest_q;
            // Divide by zero reports all-ones quotient and the raw dividend.
            if (b_q == '0) begin
              LO <= '1;
              HI <= a_q;
            end else begin
              LO <= quo_fix;
              HI <= rem_fix;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_execute_stage_muldiv.sv
`timescale 1ns/1ps
module tb_execute_stage_muldiv;

  typedef struct {
    string       name;
    logic        rw;
    bit          chk_alu;
    logic [63:0] alu;
    logic [7:0]  dest;
    logic [63:0] bt;
    bit          chk_hl;
    logic [63:0] hi;
    logic [63:0] lo;
  } exp_t;

  localparam logic [4:0] OP_ADD = 5'd0, OP_SUB = 5'd1, OP_AND = 5'd2, OP_OR = 5'd3;
  localparam logic [4:0] OP_XOR = 5'd4, OP_NOR = 5'd5, OP_SLT = 5'd6, OP_SLTU = 5'd7;
  localparam logic [4:0] OP_SLL = 5'd8, OP_SRL = 5'd9, OP_SRA = 5'd10, OP_MULT = 5'd11;
  localparam logic [4:0] OP_MULTU = 5'd12, OP_DIV = 5'd13, OP_DIVU = 5'd14;
  localparam logic [4:0] OP_MFHI = 5'd15, OP_MFLO = 5'd16, OP_MUL = 5'd17, OP_BAD = 5'd20;

  // Sign-extended small negatives; truncated to each configuration's width.
  localparam logic [63:0] M1  = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] M2  = 64'hFFFF_FFFF_FFFF_FFFE;
  localparam logic [63:0] M3  = 64'hFFFF_FFFF_FFFF_FFFD;
  localparam logic [63:0] M4  = 64'hFFFF_FFFF_FFFF_FFFC;
  localparam logic [63:0] M6  = 64'hFFFF_FFFF_FFFF_FFFA;
  localparam logic [63:0] M7  = 64'hFFFF_FFFF_FFFF_FFF9;
  localparam logic [63:0] M8  = 64'hFFFF_FFFF_FFFF_FFF8;
  localparam logic [63:0] M15 = 64'hFFFF_FFFF_FFFF_FFF1;
  localparam logic [63:0] M16 = 64'hFFFF_FFFF_FFFF_FFF0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : cfg
    localparam int W  = (g == 0) ? 32 : 16;
    localparam int MC = (g == 0) ? 4 : 1;
    localparam int SW = $clog2(W);
    localparam logic [63:0] MASK = (64'h1 << W) - 64'h1;
    localparam logic [63:0] MINV = 64'h1 << (W - 1);

    logic          rst, in_valid, alu_src, reg_dst;
    logic [4:0]    alu_op, rt, rd, reg_dest;
    logic [W-1:0]  rd1, rd2, imm_i, pc4;
    logic [SW-1:0] shamt;
    logic          stall, out_valid, reg_write, zero;
    logic [W-1:0]  alu_result, branch_target, hi, lo;
    bit            done = 1'b0;
    exp_t          q[$];

    execute_stage_muldiv #(.WIDTH(W), .REG_AW(5), .MUL_CYCLES(MC)) dut (
      .Clk(clk), .Reset(rst), .InValid(in_valid), .ALUOp(alu_op), .ALUSrc(alu_src),
      .RegDst(reg_dst), .ReadData1(rd1), .ReadData2(rd2), .Imm(imm_i), .Shamt(shamt),
      .PCPlusFour(pc4), .Rt(rt), .Rd(rd), .Stall(stall), .OutValid(out_valid),
      .RegWrite(reg_write), .ALUResult(alu_result), .Zero(zero),
      .BranchTarget(branch_target), .RegDestSelected(reg_dest), .HI(hi), .LO(lo)
    );

    function automatic logic [63:0] tr(logic [63:0] x);
      return x & MASK;
    endfunction

    always @(negedge clk) begin
      exp_t e;
      if (!rst && out_valid) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL w%0d unexpected_outvalid: got OutValid=1, expected no pending result", W);
        end else begin
          e = q.pop_front();
          check($sformatf("w%0d %s regwrite", W, e.name), 64'(reg_write), 64'(e.rw));
          if (e.chk_alu) begin
            check($sformatf("w%0d %s alu", W, e.name), 64'(alu_result), tr(e.alu));
            check($sformatf("w%0d %s zero", W, e.name), 64'(zero),
                  (tr(e.alu) == 64'h0) ? 64'h1 : 64'h0);
            check($sformatf("w%0d %s dest", W, e.name), 64'(reg_dest), 64'(e.dest));
            check($sformatf("w%0d %s bt", W, e.name), 64'(branch_target), tr(e.bt));
          end
          if (e.chk_hl) begin
            check($sformatf("w%0d %s hi", W, e.name), 64'(hi), tr(e.hi));
            check($sformatf("w%0d %s lo", W, e.name), 64'(lo), tr(e.lo));
          end
        end
      end
    end

    task automatic wait_idle();
      int n = 0;
      while (stall && n < 200) begin
        @(posedge clk); #1;
        n++;
      end
      if (stall) begin
        n_cmp++;
        n_bad++;
        $display("FAIL w%0d idle_timeout: got Stall=1, expected Stall=0 within 200 cycles", W);
      end
    endtask

    task automatic push(string nm, logic src, logic [63:0] b, logic rw, bit chk_alu,
                        logic [63:0] alu, bit chk_hl, logic [63:0] h, logic [63:0] l);
      exp_t e;
      logic [63:0] im;
      im        = src ? b : 64'd4;
      e.name    = nm;
      e.rw      = rw;
      e.chk_alu = chk_alu;
      e.alu     = alu;
      e.dest    = src ? 8'd9 : 8'd3;
      e.bt      = 64'h100 + (im << 2);
      e.chk_hl  = chk_hl;
      e.hi      = h;
      e.lo      = l;
      q.push_back(e);
    endtask

    task automatic drive(logic [4:0] op, logic [63:0] a, logic [63:0] b, logic src, int sh);
      alu_op   = op;
      alu_src  = src;
      reg_dst  = ~src;
      rd1      = W'(a);
      rd2      = src ? W'(64'hDEAD) : W'(b);
      imm_i    = src ? W'(b) : W'(64'd4);
      shamt    = SW'(sh);
      pc4      = W'(64'h100);
      rt       = 5'd9;
      rd       = 5'd3;
      in_valid = 1'b1;
    endtask

    task automatic release_and_count(string nm, int stall_exp);
      int n = 0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      rd1 = ~rd1; rd2 = ~rd2; imm_i = ~imm_i; shamt = ~shamt; rt = 5'd1; rd = 5'd2;
      while (stall && n < 200) begin
        @(posedge clk); #1;
        n++;
      end
      check($sformatf("w%0d %s stall_cycles", W, nm), 64'(n), 64'(stall_exp));
    endtask

    task automatic issue(string nm, logic [4:0] op, logic [63:0] a, logic [63:0] b, logic src,
                         int sh, int stall_exp, logic rw, bit chk_alu, logic [63:0] alu,
                         bit chk_hl, logic [63:0] h, logic [63:0] l);
      wait_idle();
      push(nm, src, b, rw, chk_alu, alu, chk_hl, h, l);
      drive(op, a, b, src, sh);
      release_and_count(nm, stall_exp);
    endtask

    initial begin
      int n;
      rst = 1'b1; in_valid = 1'b0; alu_op = '0; alu_src = 1'b0; reg_dst = 1'b0;
      rd1 = '0; rd2 = '0; imm_i = '0; pc4 = '0; shamt = '0; rt = '0; rd = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      check($sformatf("w%0d reset outvalid", W), 64'(out_valid), 64'h0);
      check($sformatf("w%0d reset stall", W), 64'(stall), 64'h0);
      check($sformatf("w%0d reset hi", W), 64'(hi), 64'h0);
      check($sformatf("w%0d reset lo", W), 64'(lo), 64'h0);
      check($sformatf("w%0d reset alu", W), 64'(alu_result), 64'h0);
      check($sformatf("w%0d reset regwrite", W), 64'(reg_write), 64'h0);
      @(posedge clk); #1;

      //      name        op        A         B        src sh stall   rw al alu          hl hi    lo
      issue("add_imm",   OP_ADD,   64'd5,    M3,      1, 0, 0,      1, 1, 64'd2,       0, 0,    0);
      issue("sub_zero",  OP_SUB,   64'h1234, 64'h1234,0, 0, 0,      1, 1, 64'd0,       0, 0,    0);
      issue("add_wrap",  OP_ADD,   M1,       64'd1,   0, 0, 0,      1, 1, 64'd0,       0, 0,    0);
      issue("and",       OP_AND,   64'hF0,   64'h3C,  0, 0, 0,      1, 1, 64'h30,      0, 0,    0);
      issue("or",        OP_OR,    64'hF0,   64'h3C,  0, 0, 0,      1, 1, 64'hFC,      0, 0,    0);
      issue("xor",       OP_XOR,   64'hF0,   64'h3C,  0, 0, 0,      1, 1, 64'hCC,      0, 0,    0);
      issue("nor",       OP_NOR,   64'hF0,   64'h3C,  0, 0, 0,      1, 1, 64'hFFFF_FFFF_FFFF_FF03, 0, 0, 0);
      issue("slt",       OP_SLT,   M1,       64'd1,   0, 0, 0,      1, 1, 64'd1,       0, 0,    0);
      issue("sltu",      OP_SLTU,  M1,       64'd1,   0, 0, 0,      1, 1, 64'd0,       0, 0,    0);
      issue("sltu_lo",   OP_SLTU,  64'd1,    M1,      0, 0, 0,      1, 1, 64'd1,       0, 0,    0);
      issue("sll",       OP_SLL,   64'd0,    64'd3,   0, 4, 0,      1, 1, 64'h30,      0, 0,    0);
      issue("srl",       OP_SRL,   64'd0,    M16,     0, 4, 0,      1, 1, MASK >> 4,   0, 0,    0);
      issue("sra",       OP_SRA,   64'd0,    M16,     0, 2, 0,      1, 1, M4,          0, 0,    0);
      issue("undef",     OP_BAD,   64'd5,    64'd5,   0, 0, 0,      0, 1, 64'd0,       0, 0,    0);
      issue("mult",      OP_MULT,  M2,       64'd3,   0, 0, MC,     0, 0, 0,           1, M1,   M6);
      issue("mflo",      OP_MFLO,  64'd0,    64'd0,   0, 0, 0,      1, 1, M6,          0, 0,    0);
      issue("mfhi",      OP_MFHI,  64'd0,    64'd0,   0, 0, 0,      1, 1, M1,          0, 0,    0);
      issue("multu",     OP_MULTU, M1,       64'd2,   0, 0, MC,     0, 0, 0,           1, 64'd1, M2);
      issue("mul",       OP_MUL,   M3,       64'd5,   0, 0, MC,     1, 1, M15,         1, 64'd1, M2);
      issue("div",       OP_DIV,   M7,       64'd2,   0, 0, W + 1,  0, 0, 0,           1, M1,   M3);
      issue("mflo_div",  OP_MFLO,  64'd0,    64'd0,   0, 0, 0,      1, 1, M3,          0, 0,    0);
      issue("divu_zero", OP_DIVU,  64'd7,    64'd0,   0, 0, W + 1,  0, 0, 0,           1, 64'd7, M1);
      issue("div_negb",  OP_DIV,   64'd7,    M2,      0, 0, W + 1,  0, 0, 0,           1, 64'd1, M3);
      issue("div_zero",  OP_DIV,   M8,       64'd0,   0, 0, W + 1,  0, 0, 0,           1, M8,   M1);
      issue("div_min",   OP_DIV,   MINV,     M1,      0, 0, W + 1,  0, 0, 0,           1, 64'd0, MINV);
      issue("divu",      OP_DIVU,  64'd100,  64'd7,   0, 0, W + 1,  0, 0, 0,           1, 64'd2, 64'd14);

      // ADD held on InValid through a DIV: must be accepted once, after Stall falls.
      wait_idle();
      push("held_div", 1'b0, 64'd2, 1'b0, 1'b0, 64'd0, 1'b1, M1, M3);
      drive(OP_DIV, M7, 64'd2, 1'b0, 0);
      @(posedge clk); #1;
      push("held_add", 1'b1, M3, 1'b1, 1'b1, 64'd2, 1'b0, 64'd0, 64'd0);
      drive(OP_ADD, 64'd5, M3, 1'b1, 0);
      n = 0;
      while (stall && n < 200) begin
        @(posedge clk); #1;
        n++;
      end
      check($sformatf("w%0d held stall_cycles", W), 64'(n), 64'(W + 1));
      @(posedge clk); #1;
      in_valid = 1'b0;
      check($sformatf("w%0d held no_restall", W), 64'(stall), 64'h0);
      repeat (3) @(posedge clk);
      #1;

      // Reset in the middle of a divide.
      wait_idle();
      drive(OP_DIVU, 64'd100, 64'd7, 1'b0, 0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check($sformatf("w%0d midreset stall", W), 64'(stall), 64'h0);
      check($sformatf("w%0d midreset hi", W), 64'(hi), 64'h0);
      check($sformatf("w%0d midreset lo", W), 64'(lo), 64'h0);
      check($sformatf("w%0d midreset outvalid", W), 64'(out_valid), 64'h0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      issue("post_reset", OP_ADD, 64'd5, M3, 1, 0, 0, 1, 1, 64'd2, 0, 0, 0);
      issue("post_mflo",  OP_MFLO, 64'd0, 64'd0, 0, 0, 0, 1, 1, 64'd0, 0, 0, 0);

      repeat (5) @(posedge clk);
      #1;
      check($sformatf("w%0d queue_empty", W), 64'(q.size()), 64'h0);
      done = 1'b1;
    end
  end

  initial begin
    for (int i = 0; i < 20000; i++) begin
      if (cfg[0].done && cfg[1].done) break;
      @(posedge clk);
    end
    if (!(cfg[0].done && cfg[1].done)) begin
      n_cmp++;
      n_bad++;
      $display("FAIL run_timeout: got unfinished run, expected both configurations done");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
